// File: rtl/i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter
//
// Shares a single i2c_master between NREQ requesters. Requesters are served
// round-robin. Each transaction is a single-byte read or write. The arbiter
// latches the winner's address, data and direction, then drives the master
// enable/ready handshake. It returns read data to the requester, followed by
// either a done pulse or, if a phase stalls, a watchdog err pulse.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   req_i          request level per requester
//   req_addr_i     packed 7-bit slave addresses, slice i = [7i+6:7i]
//   req_data_i     packed 8-bit write data, slice i = [8i+7:8i]
//   req_rw_i       per requester: 0 = write, 1 = read
//   gnt_o          one-hot grant, high while the requester owns the master
//   done_o         one-cycle pulse on successful completion
//   err_o          one-cycle pulse on watchdog abort
//   rd_data_o      read data captured at read completion, held until next read
//   m_addr_o       address to the master
//   m_data_in_o    write data to the master
//   m_rw_o         direction to the master
//   m_enable_o     enable to the master
//   m_ready_i      master ready (high = idle)
//   m_data_out_i   master read data
// ---------------------------------------------------------------------------
module i2c_master_arbiter #(
    parameter int               NREQ    = 4,
    parameter int               TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_CYC = 16'd50000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NREQ-1:0]     req_i,
    input  logic [7*NREQ-1:0]   req_addr_i,
    input  logic [8*NREQ-1:0]   req_data_i,
    input  logic [NREQ-1:0]     req_rw_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic [NREQ-1:0]     done_o,
    output logic [NREQ-1:0]     err_o,
    output logic [7:0]          rd_data_o,
    output logic [6:0]          m_addr_o,
    output logic [7:0]          m_data_in_o,
    output logic                m_rw_o,
    output logic                m_enable_o,
    input  logic                m_ready_i,
    input  logic [7:0]          m_data_out_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_FIN
    } state_e;

    state_e             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [NREQ-1:0]    err_q, err_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic [6:0]         m_addr_q, m_addr_d;
    logic [7:0]         m_data_q, m_data_d;
    logic               m_rw_q, m_rw_d;
    logic               m_enable_q, m_enable_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [TMO_W-1:0]   wdog_q, wdog_d;

    logic [6:0]         addr_arr [NREQ];
    logic [7:0]         data_arr [NREQ];

    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand;
    logic               timeout;
    logic [IDX_W-1:0]   next_ptr;

    // Unpack the flat requester buses into per-requester arrays.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr_i[7*gi +: 7];
        assign data_arr[gi] = req_data_i[8*gi +: 8];
    end

    // Round-robin pick: scan offsets from the highest down so that the
    // smallest offset from rr_ptr is the last to overwrite the selection.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand     = (int'(rr_ptr_q) + k) % NREQ;
            cand_idx = cand[IDX_W-1:0];
            if (req_i[cand_idx]) begin
                sel_vld = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    // The watchdog holds the number of cycles already spent in the phase.
    // Reaching TMO_CYC therefore aborts on the edge TMO_CYC+1 cycles after
    // the phase was entered.
    assign timeout  = (wdog_q == TMO_CYC);
    assign next_ptr = (g_q == LAST_IDX) ? '0 : g_q + 1'b1;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Handshake progress takes priority over a watchdog
    // expiry that occurs in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sel_vld && m_ready_i) state_d = S_ISSUE;
            S_ISSUE: begin
                if (!m_ready_i)   state_d = S_BUSY;
                else if (timeout) state_d = S_IDLE;
            end
            S_BUSY: begin
                if (m_ready_i)    state_d = S_FIN;
                else if (timeout) state_d = S_IDLE;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next-state logic. Every output is registered.
    always_comb begin
        gnt_d      = gnt_q;
        done_d     = '0;
        err_d      = '0;
        rd_data_d  = rd_data_q;
        m_addr_d   = m_addr_q;
        m_data_d   = m_data_q;
        m_rw_d     = m_rw_q;
        m_enable_d = m_enable_q;
        rr_ptr_d   = rr_ptr_q;
        g_d        = g_q;
        wdog_d     = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (sel_vld && m_ready_i) begin
                    gnt_d      = ONE_HOT0 << sel_idx;
                    g_d        = sel_idx;
                    m_addr_d   = addr_arr[sel_idx];
                    m_data_d   = data_arr[sel_idx];
                    m_rw_d     = req_rw_i[sel_idx];
                    m_enable_d = 1'b1;
                    wdog_d     = '0;
                end
            end
            S_ISSUE: begin
                if (!m_ready_i) begin
                    m_enable_d = 1'b0;
                    wdog_d     = '0;
                end else if (timeout) begin
                    err_d      = gnt_q;
                    gnt_d      = '0;
                    m_enable_d = 1'b0;
                    rr_ptr_d   = next_ptr;
                    wdog_d     = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_BUSY: begin
                if (m_ready_i) begin
                    // done is asserted for the whole FIN cycle
                    done_d = gnt_q;
                    if (m_rw_q) rd_data_d = m_data_out_i;
                end else if (timeout) begin
                    err_d      = gnt_q;
                    gnt_d      = '0;
                    m_enable_d = 1'b0;
                    rr_ptr_d   = next_ptr;
                    wdog_d     = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_FIN: begin
                gnt_d    = '0;
                rr_ptr_d = next_ptr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rd_data_q  <= 8'h00;
            m_addr_q   <= '0;
            m_data_q   <= '0;
            m_rw_q     <= 1'b0;
            m_enable_q <= 1'b0;
            rr_ptr_q   <= '0;
            g_q        <= '0;
            wdog_q     <= '0;
        end else begin
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            m_addr_q   <= m_addr_d;
            m_data_q   <= m_data_d;
            m_rw_q     <= m_rw_d;
            m_enable_q <= m_enable_d;
            rr_ptr_q   <= rr_ptr_d;
            g_q        <= g_d;
            wdog_q     <= wdog_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rd_data_o   = rd_data_q;
    assign m_addr_o    = m_addr_q;
    assign m_data_in_o = m_data_q;
    assign m_rw_o      = m_rw_q;
    assign m_enable_o  = m_enable_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
module tb_i2c_master_arbiter;

    localparam int          NREQ    = 4;
    localparam int          TMO_W   = 16;
    localparam logic [15:0] TMO_CYC = 16'd20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [27:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_rw = '0;
    logic [3:0]  gnt, done, err;
    logic [7:0]  rd_data;
    logic [6:0]  m_addr;
    logic [7:0]  m_data_in;
    logic        m_rw, m_enable;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data_out = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2c_master_arbiter #(
        .NREQ    (NREQ),
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_rw_i     (req_rw),
        .gnt_o        (gnt),
        .done_o       (done),
        .err_o        (err),
        .rd_data_o    (rd_data),
        .m_addr_o     (m_addr),
        .m_data_in_o  (m_data_in),
        .m_rw_o       (m_rw),
        .m_enable_o   (m_enable),
        .m_ready_i    (m_ready),
        .m_data_out_i (m_data_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        req        = '0;
        req_rw     = '0;
        m_ready    = 1'b1;
        m_data_out = '0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d, input logic rw);
        req_addr[7*i +: 7] = a;
        req_data[8*i +: 8] = d;
        req_rw[i]          = rw;
        req[i]             = 1'b1;
    endtask

    // Master model: accept, stay busy, then return ready with read data.
    // Called right after a grant; returns in the FIN (done) cycle.
    task automatic master_txn(input logic [7:0] rdat, input int busy);
        m_ready = 1'b0;
        tick();
        repeat (busy) tick();
        m_ready    = 1'b1;
        m_data_out = rdat;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({gnt, done, err, rd_data, m_addr, m_data_in, m_rw, m_enable} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b done=%b err=%b rd=%h addr=%h din=%h rw=%b en=%b, want all zero",
                     gnt, done, err, rd_data, m_addr, m_data_in, m_rw, m_enable);
        end
        $display("reset: outputs gnt=%b en=%b rd=%h", gnt, m_enable, rd_data);
    endtask

    task automatic test_single_write();
        set_req(0, 7'h2A, 8'hA5, 1'b0);
        tick();
        n_checks++;
        if (gnt !== 4'b0001) begin n_fail++; $display("FAIL write_gnt: got %b want 0001", gnt); end
        n_checks++;
        if ({m_enable, m_addr, m_data_in, m_rw} !== {1'b1, 7'h2A, 8'hA5, 1'b0}) begin
            n_fail++;
            $display("FAIL write_issue: en=%b addr=%h din=%h rw=%b want 1/2a/a5/0", m_enable, m_addr, m_data_in, m_rw);
        end
        // requester inputs are ignored once latched
        req_addr[6:0] = 7'h11;
        req_data[7:0] = 8'h00;
        m_ready = 1'b0;
        tick();
        n_checks++;
        if ({m_enable, m_addr, m_data_in} !== {1'b0, 7'h2A, 8'hA5}) begin
            n_fail++;
            $display("FAIL write_accept: en=%b addr=%h din=%h want 0/2a/a5", m_enable, m_addr, m_data_in);
        end
        repeat (2) tick();
        n_checks++;
        if (done !== 4'b0000) begin n_fail++; $display("FAIL write_early_done: got %b want 0000", done); end
        m_ready = 1'b1;
        tick();
        n_checks++;
        if ({done, gnt} !== {4'b0001, 4'b0001}) begin
            n_fail++;
            $display("FAIL write_done: done=%b gnt=%b want 0001/0001", done, gnt);
        end
        req[0] = 1'b0;
        tick();
        n_checks++;
        if ({done, gnt} !== 8'h00) begin n_fail++; $display("FAIL write_release: done=%b gnt=%b want 0", done, gnt); end
        $display("write: req0 addr=2a data=a5 done seen, gnt=%b", gnt);
    endtask

    task automatic test_read();
        set_req(2, 7'h2A, 8'h00, 1'b1);
        tick();
        n_checks++;
        if ({gnt, m_rw} !== {4'b0100, 1'b1}) begin
            n_fail++;
            $display("FAIL read_gnt: gnt=%b rw=%b want 0100/1", gnt, m_rw);
        end
        master_txn(8'h3C, 2);
        n_checks++;
        if ({done, rd_data} !== {4'b0100, 8'h3C}) begin
            n_fail++;
            $display("FAIL read_done: done=%b rd=%h want 0100/3c", done, rd_data);
        end
        req[2]     = 1'b0;
        m_data_out = 8'hFF;
        repeat (2) tick();
        n_checks++;
        if ({done, rd_data} !== {4'b0000, 8'h3C}) begin
            n_fail++;
            $display("FAIL read_hold: done=%b rd=%h want 0000/3c", done, rd_data);
        end
        $display("read: req2 rd_data=%h", rd_data);
    endtask

    task automatic test_busy_master();
        m_ready = 1'b0;
        set_req(1, 7'h33, 8'h44, 1'b0);
        repeat (3) tick();
        n_checks++;
        if ({gnt, m_enable} !== 5'b0) begin
            n_fail++;
            $display("FAIL busy_no_gnt: gnt=%b en=%b want 0000/0", gnt, m_enable);
        end
        m_ready = 1'b1;
        tick();
        n_checks++;
        if ({gnt, m_enable} !== {4'b0010, 1'b1}) begin
            n_fail++;
            $display("FAIL busy_gnt: gnt=%b en=%b want 0010/1", gnt, m_enable);
        end
        master_txn(8'h00, 1);
        n_checks++;
        if (done !== 4'b0010) begin n_fail++; $display("FAIL busy_done: got %b want 0010", done); end
        req[1] = 1'b0;
        tick();
        $display("busy master: req1 granted after ready returned");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, 7'h10 + 7'(i), 8'h20 + 8'(i), 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_gnt = 4'b0001 << i;
            n_checks++;
            if ({gnt, m_addr} !== {exp_gnt, 7'h10 + 7'(i)}) begin
                n_fail++;
                $display("FAIL rr_gnt%0d: gnt=%b addr=%h want %b/%h", i, gnt, m_addr, exp_gnt, 7'h10 + 7'(i));
            end
            master_txn(8'h00, 1);
            n_checks++;
            if (done !== exp_gnt) begin n_fail++; $display("FAIL rr_done%0d: got %b want %b", i, done, exp_gnt); end
            $display("round-robin: grant %0d done=%b", i, done);
            if (i == 3) begin
                req[1] = 1'b0;
                req[2] = 1'b0;
            end
            tick();
            n_checks++;
            if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_gap%0d: gnt=%b want 0000", i, gnt); end
            tick();
        end
        n_checks++;
        if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rr_wrap: gnt=%b want 0001", gnt); end
        master_txn(8'h00, 1);
        repeat (2) tick();
        n_checks++;
        if (gnt !== 4'b1000) begin n_fail++; $display("FAIL rr_skip: gnt=%b want 1000", gnt); end
        master_txn(8'h00, 1);
        req = '0;
        tick();
        $display("round-robin: wrap to 0 then 3 with req=1001");
    endtask

    task automatic test_timeout();
        apply_reset();
        set_req(0, 7'h05, 8'h06, 1'b0);
        set_req(1, 7'h07, 8'h08, 1'b0);
        m_ready = 1'b1;
        tick();
        n_checks++;
        if ({gnt, m_enable} !== {4'b0001, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_gnt: gnt=%b en=%b want 0001/1", gnt, m_enable);
        end
        repeat (20) tick();
        n_checks++;
        if ({err, gnt, m_enable} !== {4'b0000, 4'b0001, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_early: err=%b gnt=%b en=%b want 0000/0001/1", err, gnt, m_enable);
        end
        tick();
        n_checks++;
        if ({err, gnt, m_enable, done} !== {4'b0001, 4'b0000, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL tmo_err: err=%b gnt=%b en=%b done=%b want 0001/0000/0/0000", err, gnt, m_enable, done);
        end
        tick();
        n_checks++;
        if ({err, gnt} !== {4'b0000, 4'b0010}) begin
            n_fail++;
            $display("FAIL tmo_next: err=%b gnt=%b want 0000/0010", err, gnt);
        end
        req = '0;
        master_txn(8'h00, 1);
        tick();
        $display("timeout: err pulsed for req0, req1 granted next");
    endtask

    task automatic test_reset_mid();
        set_req(3, 7'h40, 8'h00, 1'b1);
        tick();
        master_txn(8'h5A, 1);
        n_checks++;
        if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL mid_pre_rd: got %h want 5a", rd_data); end
        req = '0;
        tick();
        set_req(3, 7'h2A, 8'h77, 1'b0);
        tick();
        m_ready = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, m_enable, m_addr, m_data_in, m_rw, rd_data} !== '0) begin
            n_fail++;
            $display("FAIL mid_async: gnt=%b en=%b addr=%h din=%h rw=%b rd=%h want all zero",
                     gnt, m_enable, m_addr, m_data_in, m_rw, rd_data);
        end
        m_ready = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({done, err, gnt} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_no_pulse: done=%b err=%b gnt=%b want 0", done, err, gnt);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({gnt, m_addr} !== {4'b1000, 7'h2A}) begin
            n_fail++;
            $display("FAIL mid_regrant: gnt=%b addr=%h want 1000/2a", gnt, m_addr);
        end
        master_txn(8'h00, 1);
        n_checks++;
        if (done !== 4'b1000) begin n_fail++; $display("FAIL mid_done: got %b want 1000", done); end
        req = '0;
        tick();
        $display("reset mid-transaction: aborted silently, new request completed");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_busy_master();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter and transaction sequencer that shares one `i2c_master` between `NREQ` independent requesters. Each requester posts a single-byte read or write (7-bit address, data, rw). The arbiter grants one requester, drives the master's `addr`/`data_in`/`rw`/`enable`, tracks the `ready` handshake to completion, and returns read data plus a done or timeout indication to the granted requester. It sits between client logic and the `i2c_master` instance inside `top`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TMO_W`, 16: width of the watchdog counter.
- `TMO_CYC`, 16'd50000: cycles allowed per phase (accept or complete) before abort; must be ≥ 2.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in NREQ: request level per requester; held high until `done`/`err` for that requester.
- `req_addr` in 7*NREQ: packed slave address per requester; slice i = bits [7i+6:7i].
- `req_data` in 8*NREQ: packed write data per requester.
- `req_rw` in NREQ: 0 = write, 1 = read.
- `gnt` out NREQ: one-hot; high while the requester owns the master.
- `done` out NREQ: one-cycle pulse on successful completion.
- `err` out NREQ: one-cycle pulse on watchdog abort.
- `rd_data` out 8: master `data_out` captured at completion of a read; valid in the `done` cycle and held until the next capture.
- `m_addr` out 7, `m_data_in` out 8, `m_rw` out 1: to master.
- `m_enable` out 1: to master.
- `m_ready` in 1: from master; high = idle.
- `m_data_out` in 8: from master.

## Operation
- States: IDLE, ISSUE, BUSY, FIN.
- **IDLE**
  - If any `req` bit is set and `m_ready` = 1, select the first requester at or after `rr_ptr` (ascending, wrapping).
  - Register the selected requester's addr/data/rw into `m_addr`/`m_data_in`/`m_rw`.
  - Set the matching `gnt` bit and `m_enable` = 1; clear the watchdog; go to ISSUE.
  - If `m_ready` = 0, stay in IDLE. No grant is issued while the master is busy.
- **ISSUE**
  - Hold `m_enable` = 1 until `m_ready` is sampled 0 (master accepted). Then set `m_enable` = 0, clear the watchdog, go to BUSY.
- **BUSY**
  - Wait for `m_ready` = 1.
  - On that cycle: if rw = 1, capture `m_data_out` into `rd_data`. Go to FIN.
- **FIN** (one cycle)
  - Pulse `done[g]`, clear `gnt`.
  - Set `rr_ptr` = (g+1) mod NREQ. Go to IDLE.
- **Watchdog**
  - Counts every cycle in ISSUE and BUSY.
  - On reaching `TMO_CYC`: set `m_enable` = 0, pulse `err[g]` (not `done`), clear `gnt`, advance `rr_ptr` as in FIN, go to IDLE.
  - `rd_data` is unchanged on abort.
- `m_addr`/`m_data_in`/`m_rw` are stable from the grant cycle until the next grant. Requester inputs are ignored after latching.
- A requester dropping `req` mid-transaction has no effect; the transaction finishes and `done` still pulses.
- At most one `gnt`, `done` or `err` bit is high in any cycle.
- A requester that re-asserts `req` the cycle after its `done` is served only after every other pending requester (fairness).

## Timing
- Reset (async assert, sync release): state IDLE, `gnt` = 0, `done` = 0, `err` = 0, `rd_data` = 8'h00, `m_addr` = 0, `m_data_in` = 0, `m_rw` = 0, `m_enable` = 0, `rr_ptr` = 0, watchdog = 0.
- Reset mid-transaction aborts with no `done`/`err` pulse, and `m_enable` drops immediately.
- Grant latency: `req` sampled high in IDLE → `gnt` and `m_enable` high on the next edge (1 cycle).
- Completion: `m_ready` sampled high in BUSY → FIN → `done` high 1 cycle later. `rd_data` updates on the same edge that enters FIN.
- Minimum back-to-back spacing: FIN → IDLE → grant, i.e. 2 cycles from a `done` pulse to the next `gnt`.
- Watchdog: `err` rises exactly `TMO_CYC` + 1 cycles after entry to the stalled state.

## Test plan
- **Single write:** reset, `req[0]` with addr 7'h2A, data 8'hA5, rw 0.
  - `m_addr` = 2A and `m_data_in` = A5 with `m_enable` 1 cycle after `req`.
  - `done[0]` 1 cycle after master `ready` returns.
- **Read:** `req[2]`, addr 2A, rw 1, master/slave returns 8'h3C.
  - `rd_data` = 3C in the `done[2]` cycle.
  - `rd_data` still 3C afterwards.
- **Round-robin:** `req` = 4'b1111 held, each re-asserted after its done.
  - Grant order 0,1,2,3,0.
  - Then with `req` = 4'b1001 after serving 3: next grant is 0.
- **Busy master:** force `m_ready` = 0 while `req[1]` is asserted.
  - No `gnt` until `m_ready` = 1.
  - Then `gnt[1]` 1 cycle later.
- **Timeout:** `TMO_CYC` = 20, `m_ready` stuck 1 (never accepts).
  - `err[0]` pulses 21 cycles after ISSUE entry.
  - `m_enable` = 0, no `done`, next requester granted.
- **Reset mid-transaction:** assert `rst` = 0 during BUSY.
  - All outputs go to reset values asynchronously, with no `done`/`err` pulse.
  - After release, a new request completes normally.
